// File: rtl/spi_buf_pkg.sv
// Shared definitions for the SPI buffer controller: the host buffer-select
// values and the host access state machine encoding.
package spi_buf_pkg;

  localparam logic SEL_RC = 1'b0;
  localparam logic SEL_TX = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACK
  } hostState_t;

endpackage

// File: rtl/spi_pkt_tracker.sv
// Synchronizes slave select, finds packet boundaries, counts rc bytes per
// packet and publishes rx/tx mailbox status flags.
module spi_pkt_tracker
  import spi_buf_pkg::*;
#(
  parameter int AddrBits = 12
) (
  input  logic                SysClk,
  input  logic                Reset,
  input  logic                SPI_SS,
  input  logic                spiRcWE,
  input  logic [AddrBits-1:0] spiTxAddr,
  input  logic                rxClear,
  input  logic                txArm,
  output logic                ssSync,
  output logic                rxReady,
  output logic [AddrBits:0]   rxCount,
  output logic                rxOverflow,
  output logic                txDone
);

  localparam logic [AddrBits:0] PktMax = {1'b1, {AddrBits{1'b0}}};

  logic              ssMeta;
  logic              ssPrev;
  logic              pktStart;
  logic              pktEnd;
  logic [AddrBits:0] pktCnt;

  assign pktStart = ssPrev & ~ssSync;
  assign pktEnd   = ~ssPrev & ssSync;

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      ssMeta     <= 1'b1;
      ssSync     <= 1'b1;
      ssPrev     <= 1'b1;
      pktCnt     <= '0;
      rxReady    <= 1'b0;
      rxCount    <= '0;
      rxOverflow <= 1'b0;
      txDone     <= 1'b0;
    end else begin
      ssMeta <= SPI_SS;
      ssSync <= ssMeta;
      ssPrev <= ssSync;

      // A write landing on the start cycle belongs to the new packet.
      if (pktStart)
        pktCnt <= (AddrBits+1)'(spiRcWE);
      else if (!ssSync && spiRcWE && pktCnt != PktMax)
        pktCnt <= pktCnt + 1'b1;

      if (pktEnd && pktCnt != '0) begin
        rxCount <= pktCnt;
        rxReady <= 1'b1;
        if (rxReady)
          rxOverflow <= 1'b1;
      end else if (rxClear) begin
        rxReady    <= 1'b0;
        rxOverflow <= 1'b0;
      end

      if (pktEnd && spiTxAddr != '0)
        txDone <= 1'b1;
      else if (txArm)
        txDone <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_buf_ctrl.sv
// Arbitrates the rc/tx byte RAMs between the SPI slave (always wins) and a
// stalling host request port, and exposes packet mailbox status.
module spi_buf_ctrl
  import spi_buf_pkg::*;
#(
  parameter int AddrBits = 12
) (
  input  logic                SysClk,
  input  logic                Reset,
  input  logic                SPI_SS,
  input  logic [AddrBits-1:0] spiRcAddr,
  input  logic [7:0]          spiRcData,
  input  logic                spiRcWE,
  input  logic [AddrBits-1:0] spiTxAddr,
  output logic [7:0]          spiTxData,
  output logic [AddrBits-1:0] rcramAddr,
  output logic [7:0]          rcramDin,
  output logic                rcramWE,
  input  logic [7:0]          rcramDout,
  output logic [AddrBits-1:0] txramAddr,
  output logic [7:0]          txramDin,
  output logic                txramWE,
  input  logic [7:0]          txramDout,
  input  logic                hostReq,
  input  logic                hostWe,
  input  logic                hostSel,
  input  logic [AddrBits-1:0] hostAddr,
  input  logic [7:0]          hostWData,
  output logic [7:0]          hostRData,
  output logic                hostAck,
  input  logic                rxClear,
  input  logic                txArm,
  output logic                rxReady,
  output logic [AddrBits:0]   rxCount,
  output logic                rxOverflow,
  output logic                txDone
);

  hostState_t state, stateNext;
  logic       ssSync;
  logic       hostRcGrant;
  logic       hostTxGrant;

  spi_pkt_tracker #(
    .AddrBits(AddrBits)
  ) uTracker (
    .SysClk    (SysClk),
    .Reset     (Reset),
    .SPI_SS    (SPI_SS),
    .spiRcWE   (spiRcWE),
    .spiTxAddr (spiTxAddr),
    .rxClear   (rxClear),
    .txArm     (txArm),
    .ssSync    (ssSync),
    .rxReady   (rxReady),
    .rxCount   (rxCount),
    .rxOverflow(rxOverflow),
    .txDone    (txDone)
  );

  always_ff @(posedge SysClk) begin
    if (Reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  // Grants and acks are suppressed while Reset is held so an in-flight
  // access never touches RAM or completes during reset.
  always_comb begin
    stateNext   = state;
    hostAck     = 1'b0;
    hostRData   = '0;
    hostRcGrant = 1'b0;
    hostTxGrant = 1'b0;
    if (!Reset) begin
      case (state)
        IDLE: begin
          if (hostReq)
            stateNext = ISSUE;
        end
        ISSUE: begin
          if (hostSel == SEL_RC && !spiRcWE) begin
            hostRcGrant = 1'b1;
            stateNext   = ACK;
          end else if (hostSel == SEL_TX && ssSync) begin
            hostTxGrant = 1'b1;
            stateNext   = ACK;
          end
        end
        ACK: begin
          hostAck   = 1'b1;
          hostRData = (hostSel == SEL_TX) ? txramDout : rcramDout;
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign rcramWE   = spiRcWE | (hostRcGrant & hostWe);
  assign rcramAddr = hostRcGrant ? hostAddr : spiRcAddr;
  assign rcramDin  = hostRcGrant ? hostWData : spiRcData;

  assign txramWE   = hostTxGrant & hostWe;
  assign txramAddr = hostTxGrant ? hostAddr : spiTxAddr;
  assign txramDin  = hostWData;

  assign spiTxData = txramDout;

endmodule

// File: tb/tb_spi_buf_ctrl.sv
// Directed and randomized bench for spi_buf_ctrl with behavioural RAMs and
// a mailbox model built from packet-level rules.
module tb_spi_buf_ctrl;
  import spi_buf_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic          SysClk;
  logic          Reset;
  logic          SPI_SS;
  logic [AW-1:0] spiRcAddr;
  logic [7:0]    spiRcData;
  logic          spiRcWE;
  logic [AW-1:0] spiTxAddr;
  logic [7:0]    spiTxData;
  logic [AW-1:0] rcramAddr;
  logic [7:0]    rcramDin;
  logic          rcramWE;
  logic [7:0]    rcramDout;
  logic [AW-1:0] txramAddr;
  logic [7:0]    txramDin;
  logic          txramWE;
  logic [7:0]    txramDout;
  logic          hostReq;
  logic          hostWe;
  logic          hostSel;
  logic [AW-1:0] hostAddr;
  logic [7:0]    hostWData;
  logic [7:0]    hostRData;
  logic          hostAck;
  logic          rxClear;
  logic          txArm;
  logic          rxReady;
  logic [AW:0]   rxCount;
  logic          rxOverflow;
  logic          txDone;

  spi_buf_ctrl #(
    .AddrBits(AW)
  ) dut (
    .SysClk    (SysClk),
    .Reset     (Reset),
    .SPI_SS    (SPI_SS),
    .spiRcAddr (spiRcAddr),
    .spiRcData (spiRcData),
    .spiRcWE   (spiRcWE),
    .spiTxAddr (spiTxAddr),
    .spiTxData (spiTxData),
    .rcramAddr (rcramAddr),
    .rcramDin  (rcramDin),
    .rcramWE   (rcramWE),
    .rcramDout (rcramDout),
    .txramAddr (txramAddr),
    .txramDin  (txramDin),
    .txramWE   (txramWE),
    .txramDout (txramDout),
    .hostReq   (hostReq),
    .hostWe    (hostWe),
    .hostSel   (hostSel),
    .hostAddr  (hostAddr),
    .hostWData (hostWData),
    .hostRData (hostRData),
    .hostAck   (hostAck),
    .rxClear   (rxClear),
    .txArm     (txArm),
    .rxReady   (rxReady),
    .rxCount   (rxCount),
    .rxOverflow(rxOverflow),
    .txDone    (txDone)
  );

  initial SysClk = 1'b0;
  always #5 SysClk = ~SysClk;

  // Synchronous-read byte RAMs attached to the controller's RAM ports.
  logic [7:0] rcMem [DEPTH];
  logic [7:0] txMem [DEPTH];
  always @(posedge SysClk) begin
    if (rcramWE) rcMem[rcramAddr] <= rcramDin;
    rcramDout <= rcMem[rcramAddr];
    if (txramWE) txMem[txramAddr] <= txramDin;
    txramDout <= txMem[txramAddr];
  end

  // Reference model state.
  logic [7:0]    refRc [DEPTH];
  logic [7:0]    refTx [DEPTH];
  logic [AW-1:0] spiAddrs [$];
  bit            expReady;
  bit            expOvf;
  bit            expTxDone;
  int            expCount;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge SysClk);
  endtask

  task automatic hostAccess(input logic sel, input logic we, input logic [AW-1:0] addr,
                            input logic [7:0] wd, output int lat, output logic [7:0] rd);
    hostSel   = sel;
    hostWe    = we;
    hostAddr  = addr;
    hostWData = wd;
    hostReq   = 1'b1;
    lat = 0;
    rd  = '0;
    while (lat < 50) begin
      @(negedge SysClk);
      lat++;
      if (hostAck) begin
        rd = hostRData;
        break;
      end
    end
    hostReq = 1'b0;
    if (we) begin
      if (sel == SEL_TX) refTx[addr] = wd;
      else               refRc[addr] = wd;
    end
    tick();
  endtask

  task automatic checkFlags(input string tag);
    check({tag, ".rxReady"},    32'(rxReady),    32'(expReady));
    check({tag, ".rxCount"},    32'(rxCount),    32'(expCount));
    check({tag, ".rxOverflow"}, 32'(rxOverflow), 32'(expOvf));
    check({tag, ".txDone"},     32'(txDone),     32'(expTxDone));
  endtask

  task automatic pulseRxClear();
    rxClear = 1'b1;
    tick();
    rxClear  = 1'b0;
    expReady = 0;
    expOvf   = 0;
  endtask

  task automatic pulseTxArm();
    txArm = 1'b1;
    tick();
    txArm     = 1'b0;
    expTxDone = 0;
  endtask

  // One packet: n rc writes with random addresses, tx reads checked, then end.
  task automatic doPacket(input int n, input logic [AW-1:0] txEnd, input int gap);
    logic [AW-1:0] a;
    logic [AW-1:0] ta;
    logic [7:0]    d;
    SPI_SS = 1'b0;
    tick(3);
    for (int i = 0; i < n; i++) begin
      a  = AW'($urandom);
      ta = AW'($urandom);
      d  = 8'($urandom);
      spiRcAddr = a;
      spiRcData = d;
      spiRcWE   = 1'b1;
      spiTxAddr = ta;
      refRc[a]  = d;
      if (n <= 64) spiAddrs.push_back(a);
      tick();
      spiRcWE = 1'b0;
      if (i < 32) check("spiTxData", 32'(spiTxData), 32'(refTx[ta]));
      tick(gap);
    end
    spiTxAddr = txEnd;
    SPI_SS    = 1'b1;
    tick(2);
    checkFlags("pktEndEarly");
    tick();
    if (n > 0) begin
      if (expReady) expOvf = 1;
      expReady = 1;
      expCount = (n > DEPTH) ? DEPTH : n;
    end
    if (txEnd != '0) expTxDone = 1;
    checkFlags("pktEnd");
    spiTxAddr = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat;
    int            acks;
    logic [7:0]    rd;
    logic [7:0]    d;
    logic [AW-1:0] a;

    for (int i = 0; i < DEPTH; i++) begin
      rcMem[i] = '0; txMem[i] = '0; refRc[i] = '0; refTx[i] = '0;
    end
    Reset = 1'b1; SPI_SS = 1'b1;
    spiRcAddr = '0; spiRcData = '0; spiRcWE = 1'b0; spiTxAddr = '0;
    hostReq = 1'b0; hostWe = 1'b0; hostSel = SEL_RC; hostAddr = '0; hostWData = '0;
    rxClear = 1'b0; txArm = 1'b0;
    expReady = 0; expOvf = 0; expTxDone = 0; expCount = 0;

    tick(3);
    check("rst.hostAck", 32'(hostAck), 32'd0);
    check("rst.hostRData", 32'(hostRData), 32'd0);
    check("rst.rcramWE", 32'(rcramWE), 32'd0);
    checkFlags("rst");
    Reset = 1'b0;
    tick();

    // Idle host write then read.
    hostAccess(SEL_RC, 1'b1, 12'h010, 8'hA5, lat, rd);
    check("wrLatency", 32'(lat), 32'd2);
    hostAccess(SEL_RC, 1'b0, 12'h010, 8'h00, lat, rd);
    check("rdLatency", 32'(lat), 32'd2);
    check("rdData", 32'(rd), 32'hA5);

    // Random idle host traffic on both buffers.
    for (int i = 0; i < 6; i++) begin
      a = AW'($urandom);
      d = 8'($urandom);
      hostAccess(1'(i), 1'b1, a, d, lat, rd);
      hostAccess(1'(i), 1'b0, a, 8'h00, lat, rd);
      check("rndRdLatency", 32'(lat), 32'd2);
      check("rndRdData", 32'(rd), 32'(((i & 1) != 0) ? refTx[a] : refRc[a]));
    end
    hostAccess(SEL_TX, 1'b1, 12'h055, 8'h6E, lat, rd);

    // Host rc write colliding with an SPI rc write in ISSUE.
    d = 8'($urandom);
    hostSel = SEL_RC; hostWe = 1'b1; hostAddr = 12'h020; hostWData = 8'h3C; hostReq = 1'b1;
    tick();
    spiRcAddr = 12'h021; spiRcData = d; spiRcWE = 1'b1;
    #1;
    check("collide.rcramAddr", 32'(rcramAddr), 32'h021);
    check("collide.rcramDin", 32'(rcramDin), 32'(d));
    tick();
    spiRcWE = 1'b0;
    check("collide.noAck", 32'(hostAck), 32'd0);
    tick();
    check("collide.ack", 32'(hostAck), 32'd1);
    hostReq = 1'b0;
    refRc[12'h020] = 8'h3C;
    refRc[12'h021] = d;
    tick();
    hostAccess(SEL_RC, 1'b0, 12'h020, 8'h00, lat, rd);
    check("collide.hostByte", 32'(rd), 32'h3C);
    hostAccess(SEL_RC, 1'b0, 12'h021, 8'h00, lat, rd);
    check("collide.spiByte", 32'(rd), 32'(d));

    // Host tx read stalled for the whole packet.
    SPI_SS = 1'b0;
    tick(3);
    hostSel = SEL_TX; hostWe = 1'b0; hostAddr = 12'h055; hostReq = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (hostAck) acks++;
    end
    check("txStall.acks", 32'(acks), 32'd0);
    SPI_SS = 1'b1;
    tick();
    check("txStall.ack1", 32'(hostAck), 32'd0);
    tick();
    check("txStall.ack2", 32'(hostAck), 32'd0);
    tick();
    check("txStall.ack3", 32'(hostAck), 32'd1);
    check("txStall.data", 32'(hostRData), 32'(refTx[12'h055]));
    hostReq = 1'b0;
    tick();
    checkFlags("emptyPkt");

    // Packet status, overflow and clear.
    doPacket(5, '0, 2);
    doPacket(3, '0, 1);
    pulseRxClear();
    checkFlags("rxClear");

    // tx consumed status.
    pulseTxArm();
    doPacket(2, 12'h004, 1);
    pulseTxArm();
    checkFlags("txArm");
    doPacket(0, '0, 1);

    // Randomized packets with random clears and arms.
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) pulseRxClear();
      if ($urandom_range(0, 2) == 0) pulseTxArm();
      doPacket(int'($urandom_range(0, 6)),
               ($urandom_range(0, 1) == 1) ? AW'($urandom) : '0,
               int'($urandom_range(1, 3)));
    end

    // Count saturates at the buffer depth.
    pulseRxClear();
    doPacket(DEPTH + 2, '0, 1);

    // Host readback of bytes written over SPI.
    for (int i = 0; i < 6; i++) begin
      a = spiAddrs[$urandom_range(0, spiAddrs.size() - 1)];
      hostAccess(SEL_RC, 1'b0, a, 8'h00, lat, rd);
      check("spiReadback", 32'(rd), 32'(refRc[a]));
    end

    // Reset in ISSUE and mid-packet.
    doPacket(1, 12'h007, 1);
    SPI_SS = 1'b0;
    tick(3);
    spiRcAddr = AW'($urandom); spiRcData = 8'($urandom); spiRcWE = 1'b1;
    tick();
    spiRcWE = 1'b0;
    hostSel = SEL_TX; hostWe = 1'b0; hostAddr = 12'h055; hostReq = 1'b1;
    tick(2);
    Reset = 1'b1;
    tick(2);
    hostReq = 1'b0;
    expReady = 0; expOvf = 0; expTxDone = 0; expCount = 0;
    check("midRst.hostAck", 32'(hostAck), 32'd0);
    check("midRst.hostRData", 32'(hostRData), 32'd0);
    checkFlags("midRst");
    Reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (hostAck) acks++;
    end
    SPI_SS = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (hostAck) acks++;
    end
    check("postRst.acks", 32'(acks), 32'd0);
    checkFlags("postRst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_buf_ctrl.md
# spi_buf_ctrl

Buffer controller that shares the SPI slave's receive (rc) and transmit (tx) byte memories between the SPI interface and a host-side request port. SPI traffic always wins; host accesses are stalled and retried. Tracks SPI packet boundaries to publish per-packet receive counts and tx-consumed status, turning the raw byte memories into a simple host mailbox. Sits between the SPI slave interface, two synchronous-read RAMs, and the host bus adapter.

## Interface
- AddrBits, 12, byte-address width of each buffer (depth 2^AddrBits)
- SysClk  in  1  system clock
- Reset  in  1  Reset, synchronous, active-high; clock SysClk
- SPI_SS  in  1  raw SPI slave select, active-low, asynchronous
- spiRcAddr  in  AddrBits  SPI-side rc write address
- spiRcData  in  8  SPI-side rc write data
- spiRcWE  in  1  SPI-side rc write strobe, single-cycle
- spiTxAddr  in  AddrBits  SPI-side tx read address
- spiTxData  out  8  tx RAM read data to SPI side
- rcramAddr / rcramDin / rcramWE  out  AddrBits/8/1  rc RAM port
- rcramDout  in  8  rc RAM read data, 1-cycle latency
- txramAddr / txramDin / txramWE  out  AddrBits/8/1  tx RAM port
- txramDout  in  8  tx RAM read data, 1-cycle latency
- hostReq  in  1  host access request, held until hostAck
- hostWe  in  1  1=write, 0=read
- hostSel  in  1  0=rc buffer, 1=tx buffer
- hostAddr  in  AddrBits  host byte address
- hostWData  in  8  host write data
- hostRData  out  8  read data, valid while hostAck=1
- hostAck  out  1  one-cycle transaction complete
- rxClear  in  1  pulse: clear rxReady/rxOverflow
- txArm  in  1  pulse: tx buffer loaded, clears txDone
- rxReady  out  1  packet with rc writes completed
- rxCount  out  AddrBits+1  rc bytes written in last completed packet
- rxOverflow  out  1  packet completed while rxReady already set
- txDone  out  1  packet consumed tx data since last txArm

## Operation
- SS: two-flop synchronizer to ssSync (reset 1). Packet start = ssSync 1->0, end = 0->1.
- rc port: rcramWE = spiRcWE | hostRcWrGrant; address/data mux selects SPI whenever spiRcWE=1, else host when granted, else spiRcAddr.
- tx port: txramAddr = spiTxAddr unless host tx access granted; host tx access granted only when ssSync=1. spiTxData = txramDout (combinational pass-through).
- Host FSM: IDLE -> ISSUE on hostReq. ISSUE: grant if (hostSel=0 and spiRcWE=0) or (hostSel=1 and ssSync=1); on grant drive RAM (write if hostWe) -> ACK; else stay ISSUE. ACK: hostAck=1, hostRData = selected RAM dout -> IDLE. hostReq still high in IDLE starts a new transaction.
- Packet tracker: pktCnt cleared at packet start, +1 per spiRcWE while ssSync=0, saturates at 2^AddrBits. At packet end with pktCnt>0: rxCount<=pktCnt; if rxReady already 1, rxOverflow<=1; rxReady<=1. Packet with no rc writes leaves rx status unchanged.
- txDone set at packet end if spiTxAddr != 0 at that cycle; cleared by txArm.
- Simultaneous rxClear and packet end: set wins. txArm and packet end same cycle: set wins.
- spiRcWE while ssSync=1 (sync skew): RAM still written, not counted.

## Timing
- Reset values: hostAck 0, hostRData 0, rxReady 0, rxCount 0, rxOverflow 0, txDone 0, FSM IDLE, pktCnt 0, ssSync 1. RAM ports follow SPI-side defaults (WE = spiRcWE).
- Host latency: req at cycle 0 -> ISSUE cycle 1 -> hostAck cycle 2 minimum; each blocked ISSUE cycle adds one. Host tx access blocked for whole packet.
- SPI rc write reaches RAM same cycle as spiRcWE (zero added latency).
- spiTxData lags spiTxAddr by one cycle; SysClk must be ≥8× SPI_CLK.
- Status flags update the cycle after synchronized packet end (3 SysClk after raw SS rise).
- Reset mid-transaction: FSM to IDLE, no hostAck issued, partial packet discarded.

## Structure
- Shared package spi_buf_pkg: SEL_RC/SEL_TX constants, host FSM state encoding (IDLE/ISSUE/ACK).
- Sub-module spi_pkt_tracker: SS synchronizer, edge detect, pktCnt, rx/tx status flags. Top holds muxes and host FSM.

## Test plan
- Host write 0xA5 to rc addr 0x010 idle, then read -> hostAck at cycle 2 each, hostRData=0xA5.
- Host rc write in ISSUE same cycle as spiRcWE (addr 0x020, 0x3C) -> SPI byte written first, host delayed 1 cycle, both bytes readable.
- Host tx read during SS low -> no ack until 2 cycles after SS synchronizes high.
- Packet with 5 spiRcWE -> rxReady=1, rxCount=5; second 3-byte packet without rxClear -> rxCount=3, rxOverflow=1; rxClear clears both.
- txArm, packet ending with spiTxAddr=4 -> txDone=1; empty packet after txArm -> txDone stays 0.
- Reset asserted in ISSUE and mid-packet -> all outputs return to reset values, no stray hostAck, rxReady stays 0.
